// File: rtl/softmax_argmax.sv
// softmax_argmax: two-class argmax over float32 probabilities, with a
// confidence flag and a small result FIFO.
// Optional feature macro: SOFTMAX_ARGMAX_STATS_EN. When it is defined,
// saturating per-class counters of accepted results are built. Otherwise
// cnt0/cnt1 are tied to zero.
module softmax_argmax #(
  parameter logic [31:0] THRESH = 32'h3F000000,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [31:0]                percent0,
  input  logic [31:0]                percent1,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_class,
  output logic [31:0]                out_percent,
  output logic                       out_lowconf,
  output logic                       out_nan,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic        cls;
    logic [31:0] pct;
    logic        low;
    logic        nan;
  } entry_t;

  // A negative operand is treated as +0; otherwise the magnitude bits are compared.
  function automatic logic [30:0] mag(input logic [31:0] x);
    return x[31] ? '0 : x[30:0];
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  logic [31:0]   p0_q, p1_q;
  logic          s1;
  entry_t        res;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          pop, push, full;

  // Stage 1: capture operands on valid_in and pulse s1 for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_q <= '0;
      p1_q <= '0;
      s1   <= 1'b0;
    end else begin
      s1 <= valid_in;
      if (valid_in) begin
        p0_q <= percent0;
        p1_q <= percent1;
      end
    end
  end

  // Stage 2: pick the winner, with NaN losing and ties going to class 0.
  always_comb begin
    logic n0, n1;
    res = '0;
    n0  = is_nan(p0_q);
    n1  = is_nan(p1_q);
    if (n0 && n1)      res.cls = 1'b0;
    else if (n0)       res.cls = 1'b1;
    else if (n1)       res.cls = 1'b0;
    else               res.cls = (mag(p1_q) > mag(p0_q));
    res.pct = res.cls ? p1_q : p0_q;
    res.nan = n0 | n1;
    res.low = is_nan(res.pct) || (mag(res.pct) < mag(THRESH));
  end

  assign full = (level == LW'(DEPTH));
  assign pop  = out_valid && out_ready;
  assign push = s1 && (!full || pop);

  // Result FIFO. The storage is reset so the head outputs are never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (s1 && !push) overflow <= 1'b1;
    end
  end

  assign out_valid   = (level != '0);
  assign out_class   = mem[rd_ptr].cls;
  assign out_percent = mem[rd_ptr].pct;
  assign out_lowconf = mem[rd_ptr].low;
  assign out_nan     = mem[rd_ptr].nan;
  assign fifo_level  = level;

`ifdef SOFTMAX_ARGMAX_STATS_EN
  // Per-class saturating counts of the results that actually entered the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (push) begin
      if (!res.cls && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (res.cls && (cnt1 != '1))  cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed self-checking bench for softmax_argmax (default parameters).
module tb_softmax_argmax;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] percent0 = '0, percent1 = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_class, out_lowconf, out_nan, overflow;
  logic [31:0] out_percent;
  logic [2:0]  fifo_level;
  logic [15:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_argmax #(.THRESH(32'h3F000000), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .percent0(percent0), .percent1(percent1), .out_ready(out_ready),
    .out_valid(out_valid), .out_class(out_class), .out_percent(out_percent),
    .out_lowconf(out_lowconf), .out_nan(out_nan), .overflow(overflow),
    .fifo_level(fifo_level), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Vector table: operands, expected winning class and percent.
  logic [31:0] v_p0  [9] = '{32'h3F400000, 32'h3E000000, 32'h3F200000, 32'h3D000000,
                             32'h3F700000, 32'h3E400000, 32'h3F300000, 32'h40000000,
                             32'h3F800000};
  logic [31:0] v_p1  [9] = '{32'h3E800000, 32'h3F000000, 32'h3F100000, 32'h3F600000,
                             32'h00000000, 32'h3E600000, 32'h3F280000, 32'h3F800000,
                             32'h3F800001};
  logic        v_cls [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] v_pct [9] = '{32'h3F400000, 32'h3F000000, 32'h3F200000, 32'h3F600000,
                             32'h3F700000, 32'h3E600000, 32'h3F300000, 32'h40000000,
                             32'h3F800001};
  // Expected output order after the overflow test drops vector 4.
  int ord [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    valid_in = v;
    percent0 = a;
    percent1 = b;
  endtask

  // Single result: pulse at N, then sample the head in N+2.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cls, input logic [31:0] pct, input logic low,
                        input logic nan);
    drive(1'b1, a, b);
    step();
    drive(1'b0, '0, '0);
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_class"}, 64'(out_class), 64'(cls));
    check({tag, "_pct"},   64'(out_percent), 64'(pct));
    check({tag, "_low"},   64'(out_lowconf), 64'(low));
    check({tag, "_nan"},   64'(out_nan), 64'(nan));
    step();
    check({tag, "_drained"}, 64'(fifo_level), 64'(0));
  endtask

  initial begin
    #1;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(1'b0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ovf",   64'(overflow), 64'(1'b0));
    check("rst_class", 64'(out_class), 64'(1'b0));
    check("rst_pct",   64'(out_percent), 64'(0));
    check("rst_cnt0",  64'(cnt0), 64'(0));
    check("rst_cnt1",  64'(cnt1), 64'(0));

    out_ready = 1'b1;
    single("basic",  32'h3F400000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0, 1'b0);
    single("low1",   32'h3EB33333, 32'h3ECCCCCD, 1'b1, 32'h3ECCCCCD, 1'b1, 1'b0);
    single("eq",     32'h3F000000, 32'h3F000000, 1'b0, 32'h3F000000, 1'b0, 1'b0);
    single("nan0",   32'h7FC00000, 32'h3DCCCCCD, 1'b1, 32'h3DCCCCCD, 1'b1, 1'b1);
    single("nanboth",32'h7FC00000, 32'hFFC00001, 1'b0, 32'h7FC00000, 1'b1, 1'b1);
    single("nan1",   32'h3E000000, 32'h7F800001, 1'b0, 32'h3E000000, 1'b1, 1'b1);
    single("zeros",  32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 1'b1, 1'b0);
    single("neg",    32'hBF800000, 32'h3C000000, 1'b1, 32'h3C000000, 1'b1, 1'b0);
    single("inf",    32'h3F000000, 32'h7F800000, 1'b1, 32'h7F800000, 1'b0, 1'b0);
    single("below",  32'h3EFFFFFF, 32'h00000000, 1'b0, 32'h3EFFFFFF, 1'b1, 1'b0);

    // Five back-to-back pulses into a stalled FIFO: the fifth is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, v_p0[i], v_p1[i]);
      step();
    end
    drive(1'b0, '0, '0);
    step();
    check("ovf_level", 64'(fifo_level), 64'(4));
    check("ovf_flag",  64'(overflow), 64'(1'b1));
    check("ovf_head",  64'(out_percent), 64'(v_pct[0]));
`ifdef SOFTMAX_ARGMAX_STATS_EN
    check("ovf_cnt0", 64'(cnt0), 64'(2));
    check("ovf_cnt1", 64'(cnt1), 64'(2));
`else
    check("ovf_cnt0", 64'(cnt0), 64'(0));
    check("ovf_cnt1", 64'(cnt1), 64'(0));
`endif

    // Full FIFO with continuous input and the consumer ready: level holds at 4.
    drive(1'b1, v_p0[5], v_p1[5]);
    step();
    check("full_level0", 64'(fifo_level), 64'(4));
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      if (j <= 3) drive(1'b1, v_p0[5 + j], v_p1[5 + j]);
      else        drive(1'b0, '0, '0);
      step();
      check($sformatf("drain_level%0d", j), 64'(fifo_level), 64'((j <= 4) ? 4 : 8 - j));
      check($sformatf("drain_ovf%0d", j), 64'(overflow), 64'(1'b1));
      if (j < 8) begin
        check($sformatf("drain_pct%0d", j), 64'(out_percent), 64'(v_pct[ord[j]]));
        check($sformatf("drain_cls%0d", j), 64'(out_class), 64'(v_cls[ord[j]]));
      end else begin
        check("drain_empty", 64'(out_valid), 64'(1'b0));
      end
    end
`ifdef SOFTMAX_ARGMAX_STATS_EN
    check("drain_cnt0", 64'(cnt0), 64'(4));
    check("drain_cnt1", 64'(cnt1), 64'(4));
`endif

    // Reset with three results buffered and valid_in high in the reset cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v_p0[i], v_p1[i]);
      step();
    end
    drive(1'b0, '0, '0);
    step();
    check("pre_rst_level", 64'(fifo_level), 64'(3));
    reset = 1'b1;
    drive(1'b1, v_p0[3], v_p1[3]);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    check("mrst_valid", 64'(out_valid), 64'(1'b0));
    check("mrst_level", 64'(fifo_level), 64'(0));
    check("mrst_ovf",   64'(overflow), 64'(1'b0));
    check("mrst_pct",   64'(out_percent), 64'(0));
    check("mrst_cnt0",  64'(cnt0), 64'(0));
    check("mrst_cnt1",  64'(cnt1), 64'(0));
    step();
    step();
    check("mrst_ignored", 64'(fifo_level), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_argmax.md
SOFTMAX_ARGMAX -- requirements
Module: softmax_argmax

Interface
- REQ-001: Parameter THRESH, default 32'h3F000000 (0.5), float32 confidence threshold.
- REQ-002: Parameter DEPTH, default 4, result FIFO depth; power of two, at least 2.
- REQ-003: Parameter CNT_W, default 16, width of the per-class statistics counters.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: valid_in  input  1  one-cycle pulse; percent0/percent1 valid this cycle.
- REQ-007: percent0  input  32  IEEE-754 single probability of class 0.
- REQ-008: percent1  input  32  IEEE-754 single probability of class 1.
- REQ-009: out_ready  input  1  consumer accepts the head entry.
- REQ-010: out_valid  output  1  FIFO head entry present.
- REQ-011: out_class  output  1  winning class index.
- REQ-012: out_percent  output  32  winning probability, float32 bits unchanged.
- REQ-013: out_lowconf  output  1  winning probability below THRESH.
- REQ-014: out_nan  output  1  at least one input was NaN.
- REQ-015: overflow  output  1  sticky: a result was dropped because the FIFO was full.
- REQ-016: fifo_level  output  $clog2(DEPTH)+1  number of occupied entries.
- REQ-017: cnt0, cnt1  output  CNT_W  accepted-result count per winning class.

Function
- REQ-018: Stage 1 SHALL register percent0/percent1 on a cycle with valid_in=1 and raise an internal valid s1 for exactly one cycle; with valid_in=0, the data registers hold and s1=0.
- REQ-019: Stage 2 SHALL compare the stage-1 operands and present the result to the FIFO push port in the cycle s1=1.
- REQ-020: Compare rule: an operand with its sign bit set is treated as +0; otherwise operands compare as unsigned bits[30:0].
- REQ-021: NaN (exponent 8'hFF, mantissa nonzero) SHALL lose to any non-NaN operand and set out_nan; if both are NaN, class 0 wins.
- REQ-022: Ties, including +0 against -0, SHALL select class 0.
- REQ-023: out_lowconf = 1 when the winning value is below THRESH under the REQ-020 rule, or when the winner is NaN.
- REQ-024: Latency: valid_in at cycle N with an empty FIFO gives out_valid=1 with that entry at the head in cycle N+2.
- REQ-025: The FIFO SHALL pop when out_valid && out_ready, and push when the stage-2 result is valid and (level < DEPTH, or a pop occurs the same cycle).
- REQ-026: Push with the FIFO full and no pop SHALL drop the result, set overflow=1, and leave cnt0/cnt1 unchanged.
- REQ-027: Simultaneous push and pop SHALL leave fifo_level unchanged at any level, including full; order is preserved (FIFO).
- REQ-028: Pointers SHALL wrap modulo DEPTH; out_class/out_percent/out_lowconf/out_nan are don't-care while out_valid=0 but SHALL be driven from the head register with no X.
- REQ-029: Back-to-back valid_in on every cycle SHALL be accepted with no bubbles at stage 1 or stage 2.

Reset
- REQ-030: With reset=1 at a clock edge, all stage registers, s1, FIFO pointers and level SHALL clear to 0, as SHALL overflow, out_valid, out_class, out_percent, out_lowconf, out_nan, cnt0 and cnt1.
- REQ-031: Reset mid-operation SHALL discard in-flight and buffered results; valid_in sampled in the reset cycle SHALL be ignored.

Configuration
- REQ-032: Macro SOFTMAX_ARGMAX_STATS_EN: when defined, cnt0/cnt1 increment by 1 on each accepted push whose out_class is 0 or 1 respectively, saturating at all-ones.
- REQ-033: Without SOFTMAX_ARGMAX_STATS_EN, cnt0/cnt1 SHALL be constant 0 and no counter registers are synthesised; all other behaviour is identical.

Verification
- REQ-034: percent0=32'h3F400000 (0.75), percent1=32'h3E800000 (0.25), out_ready=1 -> at N+2: out_valid=1, out_class=0, out_percent=32'h3F400000, out_lowconf=0.
- REQ-035: percent0=32'h3EB33333 (0.35), percent1=32'h3ECCCCCD (0.4) -> out_class=1, out_lowconf=1; then equal inputs 32'h3F000000 -> out_class=0, out_lowconf=0.
- REQ-036: percent0=32'h7FC00000 (NaN), percent1=32'h3DCCCCCD -> out_class=1, out_nan=1, out_lowconf=1.
- REQ-037: out_ready=0, 5 valid_in pulses -> fifo_level=4, overflow=1, fifth result absent; cnt0+cnt1=4 with STATS_EN.
- REQ-038: FIFO full, out_ready=1 with continuous valid_in -> level stays 4, overflow unchanged, results drain in input order.
- REQ-039: reset asserted for 1 cycle while level=3 -> next cycle out_valid=0, fifo_level=0, overflow=0, cnt0=cnt1=0.
